// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - control-word structs, forwarding selects and reference control words
package ctrl_pkg;

   typedef struct packed {
      logic       regdst;
      logic       alusrc;
      logic [1:0] aluop;
      logic [3:0] other;
      logic       memread;
      logic       memwrite;
      logic       memtoreg;
      logic       regwrite;
   } id_ctrl_t;

   typedef struct packed {
      logic       regdst;
      logic       alusrc;
      logic [1:0] aluop;
      logic [3:0] other;
   } ex_ctrl_t;

   typedef struct packed {
      logic memread;
      logic memwrite;
   } mem_ctrl_t;

   typedef struct packed {
      logic memtoreg;
      logic regwrite;
   } wb_ctrl_t;

   localparam logic [1:0] FWD_NONE = 2'b00;
   localparam logic [1:0] FWD_WB   = 2'b01;
   localparam logic [1:0] FWD_MEM  = 2'b10;

   localparam logic [11:0] CTRL_RTYPE = 12'hA01;
   localparam logic [11:0] CTRL_LW    = 12'h40B;
   localparam logic [11:0] CTRL_ADDI  = 12'h701;

endpackage

// File: rtl/ctrl_pipe_hazard_fwd_unit.sv
// rtl/ctrl_pipe_hazard_fwd_unit.sv - combinational ALU operand forwarding select for one operand
module fwd_unit
   import ctrl_pkg::*;
#(
   parameter int REG_AW = 5
) (
   input  logic              mem_regwrite,
   input  logic [REG_AW-1:0] mem_dst,
   input  logic              wb_regwrite,
   input  logic [REG_AW-1:0] wb_dst,
   input  logic [REG_AW-1:0] ex_src,
   output logic [1:0]        fwd_sel
);

   // The younger (MEM) producer wins; $0 is hardwired so it is never a forwarding source.
   always_comb begin
      fwd_sel = FWD_NONE;
      if (mem_regwrite && (mem_dst != '0) && (mem_dst == ex_src)) begin
         fwd_sel = FWD_MEM;
      end else if (wb_regwrite && (wb_dst != '0) && (wb_dst == ex_src)) begin
         fwd_sel = FWD_WB;
      end
   end

endmodule

// File: rtl/ctrl_pipe_hazard.sv
// rtl/ctrl_pipe_hazard.sv - ID/EX, EX/MEM, MEM/WB control pipeline with load-use stall and forwarding
module ctrl_pipe_hazard
   import ctrl_pkg::*;
#(
   parameter int REG_AW = 5
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_id_valid,
   input  logic [11:0]       i_id_ctrl,
   input  logic [REG_AW-1:0] i_id_rs,
   input  logic [REG_AW-1:0] i_id_rt,
   input  logic [REG_AW-1:0] i_id_rd,
   input  logic              i_flush,
   output logic              o_stall,
   output logic [7:0]        o_ex_ctrl,
   output logic [REG_AW-1:0] o_ex_rs,
   output logic [REG_AW-1:0] o_ex_rt,
   output logic [REG_AW-1:0] o_ex_dst,
   output logic [1:0]        o_mem_ctrl,
   output logic [REG_AW-1:0] o_mem_dst,
   output logic [1:0]        o_wb_ctrl,
   output logic [REG_AW-1:0] o_wb_dst,
   output logic [1:0]        o_fwd_a,
   output logic [1:0]        o_fwd_b
);

   id_ctrl_t          id_ctrl;
   id_ctrl_t          ex_q;
   logic [REG_AW-1:0] ex_rs_q, ex_rt_q, ex_rd_q;
   logic [REG_AW-1:0] ex_dst;
   mem_ctrl_t         mem_q;
   wb_ctrl_t          mem_wb_q;
   logic [REG_AW-1:0] mem_dst_q;
   wb_ctrl_t          wb_q;
   logic [REG_AW-1:0] wb_dst_q;
   ex_ctrl_t          ex_view;
   logic              bubble;

   assign id_ctrl = id_ctrl_t'(i_id_ctrl);
   assign ex_dst  = ex_q.regdst ? ex_rd_q : ex_rt_q;

   // A load in EX whose target is read by ID cannot be forwarded in time.
   assign o_stall = i_id_valid && ex_q.memread && (ex_rt_q != '0) &&
                    ((ex_rt_q == i_id_rs) || (ex_rt_q == i_id_rt));

   assign bubble = i_flush || o_stall || !i_id_valid;

   always_ff @(posedge i_clk) begin
      if (i_rst || bubble) begin
         ex_q    <= '0;
         ex_rs_q <= '0;
         ex_rt_q <= '0;
         ex_rd_q <= '0;
      end else begin
         ex_q    <= id_ctrl;
         ex_rs_q <= i_id_rs;
         ex_rt_q <= i_id_rt;
         ex_rd_q <= i_id_rd;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         mem_q     <= '0;
         mem_wb_q  <= '0;
         mem_dst_q <= '0;
      end else begin
         mem_q     <= '{memread: ex_q.memread, memwrite: ex_q.memwrite};
         mem_wb_q  <= '{memtoreg: ex_q.memtoreg, regwrite: ex_q.regwrite};
         mem_dst_q <= ex_dst;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wb_q     <= '0;
         wb_dst_q <= '0;
      end else begin
         wb_q     <= mem_wb_q;
         wb_dst_q <= mem_dst_q;
      end
   end

   assign ex_view = '{regdst: ex_q.regdst, alusrc: ex_q.alusrc,
                      aluop: ex_q.aluop, other: ex_q.other};

   assign o_ex_ctrl  = ex_view;
   assign o_ex_rs    = ex_rs_q;
   assign o_ex_rt    = ex_rt_q;
   assign o_ex_dst   = ex_dst;
   assign o_mem_ctrl = mem_q;
   assign o_mem_dst  = mem_dst_q;
   assign o_wb_ctrl  = wb_q;
   assign o_wb_dst   = wb_dst_q;

   fwd_unit #(.REG_AW(REG_AW)) u_fwd_a (
      .mem_regwrite (mem_wb_q.regwrite),
      .mem_dst      (mem_dst_q),
      .wb_regwrite  (wb_q.regwrite),
      .wb_dst       (wb_dst_q),
      .ex_src       (ex_rs_q),
      .fwd_sel      (o_fwd_a)
   );

   fwd_unit #(.REG_AW(REG_AW)) u_fwd_b (
      .mem_regwrite (mem_wb_q.regwrite),
      .mem_dst      (mem_dst_q),
      .wb_regwrite  (wb_q.regwrite),
      .wb_dst       (wb_dst_q),
      .ex_src       (ex_rt_q),
      .fwd_sel      (o_fwd_b)
   );

endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// tb/tb_ctrl_pipe_hazard.sv - table-driven bench for the control pipeline, stall and forwarding
module tb_ctrl_pipe_hazard;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        id_valid = 1'b0;
   logic [11:0] id_ctrl = '0;
   logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0;
   logic        flush = 1'b0;
   logic        stall;
   logic [7:0]  ex_ctrl;
   logic [4:0]  ex_rs, ex_rt, ex_dst, mem_dst, wb_dst;
   logic [1:0]  mem_ctrl, wb_ctrl, fwd_a, fwd_b;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   ctrl_pipe_hazard #(.REG_AW(5)) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_id_valid (id_valid),
      .i_id_ctrl  (id_ctrl),
      .i_id_rs    (id_rs),
      .i_id_rt    (id_rt),
      .i_id_rd    (id_rd),
      .i_flush    (flush),
      .o_stall    (stall),
      .o_ex_ctrl  (ex_ctrl),
      .o_ex_rs    (ex_rs),
      .o_ex_rt    (ex_rt),
      .o_ex_dst   (ex_dst),
      .o_mem_ctrl (mem_ctrl),
      .o_mem_dst  (mem_dst),
      .o_wb_ctrl  (wb_ctrl),
      .o_wb_dst   (wb_dst),
      .o_fwd_a    (fwd_a),
      .o_fwd_b    (fwd_b)
   );

   typedef struct {
      logic        rst, valid, flush, chk;
      logic [11:0] ctrl;
      logic [4:0]  rs, rt, rd;
      logic        e_stall;
      logic [7:0]  e_exc;
      logic [4:0]  e_exrs, e_exrt, e_exdst;
      logic [1:0]  e_memc;
      logic [4:0]  e_memdst;
      logic [1:0]  e_wbc;
      logic [4:0]  e_wbdst;
      logic [1:0]  e_fa, e_fb;
   } vec_t;

   vec_t vecs[$];

   localparam logic [11:0] RT = 12'hA01, LW = 12'h40B, AI = 12'h701, SW = 12'h046;

   task automatic add(input logic r, input logic v, input logic f, input logic [11:0] c,
                      input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                      input logic es, input logic [7:0] exc, input logic [4:0] exs,
                      input logic [4:0] ext, input logic [4:0] exd, input logic [1:0] mc,
                      input logic [4:0] md, input logic [1:0] wc, input logic [4:0] wd,
                      input logic [1:0] fa, input logic [1:0] fb);
      vec_t x;
      x.rst = r; x.valid = v; x.flush = f; x.chk = 1'b1; x.ctrl = c;
      x.rs = s; x.rt = t; x.rd = d; x.e_stall = es; x.e_exc = exc;
      x.e_exrs = exs; x.e_exrt = ext; x.e_exdst = exd; x.e_memc = mc;
      x.e_memdst = md; x.e_wbc = wc; x.e_wbdst = wd; x.e_fa = fa; x.e_fb = fb;
      vecs.push_back(x);
   endtask

   task automatic nop(input logic [7:0] exc, input logic [4:0] exs, input logic [4:0] ext,
                      input logic [4:0] exd, input logic [1:0] mc, input logic [4:0] md,
                      input logic [1:0] wc, input logic [4:0] wd,
                      input logic [1:0] fa, input logic [1:0] fb);
      add(0, 0, 0, 12'h000, 0, 0, 0, 0, exc, exs, ext, exd, mc, md, wc, wd, fa, fb);
   endtask

   task automatic check(input int row, input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL row %0d %s: got %0h expected %0h", row, name, act, exp);
      end
   endtask

   initial begin
      // reset: first row only establishes state, second row checks cleared outputs
      add(1, 1, 0, AI, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      vecs[0].chk = 1'b0;
      add(1, 1, 0, AI, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      nop(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      // R-type latency
      add(0, 1, 0, RT, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      nop(8'hA0, 1, 2, 3, 0, 0, 0, 0, 0, 0);
      nop(0, 0, 0, 0, 0, 3, 0, 0, 0, 0);
      nop(0, 0, 0, 0, 0, 0, 2'b01, 3, 0, 0);
      // load-use stall, then re-present
      add(0, 1, 0, LW, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      add(0, 1, 0, RT, 5, 6, 7, 1, 8'h40, 1, 5, 5, 0, 0, 0, 0, 0, 0);
      add(0, 1, 0, RT, 5, 6, 7, 0, 0, 0, 0, 0, 2'b10, 5, 0, 0, 0, 0);
      nop(8'hA0, 5, 6, 7, 0, 0, 2'b11, 5, 2'b01, 2'b00);
      nop(0, 0, 0, 0, 0, 7, 0, 0, 0, 0);
      nop(0, 0, 0, 0, 0, 0, 2'b01, 7, 0, 0);
      // ADDI then back-to-back use: MEM forward
      add(0, 1, 0, AI, 1, 4, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      add(0, 1, 0, RT, 4, 4, 8, 0, 8'h70, 1, 4, 4, 0, 0, 0, 0, 0, 0);
      nop(8'hA0, 4, 4, 8, 0, 4, 0, 0, 2'b10, 2'b10);
      nop(0, 0, 0, 0, 0, 8, 2'b01, 4, 0, 0);
      nop(0, 0, 0, 0, 0, 0, 2'b01, 8, 0, 0);
      // one bubble between: WB forward
      add(0, 1, 0, AI, 1, 4, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      nop(8'h70, 1, 4, 4, 0, 0, 0, 0, 0, 0);
      add(0, 1, 0, RT, 4, 4, 8, 0, 0, 0, 0, 0, 0, 4, 0, 0, 0, 0);
      nop(8'hA0, 4, 4, 8, 0, 0, 2'b01, 4, 2'b01, 2'b01);
      nop(0, 0, 0, 0, 0, 8, 0, 0, 0, 0);
      nop(0, 0, 0, 0, 0, 0, 2'b01, 8, 0, 0);
      // MEM and WB both target 4: MEM wins
      add(0, 1, 0, AI, 1, 4, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      add(0, 1, 0, AI, 2, 4, 9, 0, 8'h70, 1, 4, 4, 0, 0, 0, 0, 0, 0);
      add(0, 1, 0, RT, 4, 4, 8, 0, 8'h70, 2, 4, 4, 0, 4, 0, 0, 2'b00, 2'b10);
      nop(8'hA0, 4, 4, 8, 0, 4, 2'b01, 4, 2'b10, 2'b10);
      nop(0, 0, 0, 0, 0, 8, 2'b01, 4, 0, 0);
      nop(0, 0, 0, 0, 0, 0, 2'b01, 8, 0, 0);
      // load to $0: no stall, no forward
      add(0, 1, 0, LW, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      add(0, 1, 0, RT, 0, 3, 8, 0, 8'h40, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      nop(8'hA0, 0, 3, 8, 2'b10, 0, 0, 0, 0, 0);
      nop(0, 0, 0, 0, 0, 8, 2'b11, 0, 0, 0);
      nop(0, 0, 0, 0, 0, 0, 2'b01, 8, 0, 0);
      // store ahead of use: never forwards
      add(0, 1, 0, SW, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      add(0, 1, 0, RT, 7, 7, 8, 0, 8'h04, 1, 7, 7, 0, 0, 0, 0, 0, 0);
      nop(8'hA0, 7, 7, 8, 2'b01, 7, 0, 0, 0, 0);
      nop(0, 0, 0, 0, 0, 8, 2'b10, 7, 0, 0);
      nop(0, 0, 0, 0, 0, 0, 2'b01, 8, 0, 0);
      // flush coincident with stall: a single bubble
      add(0, 1, 0, LW, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      add(0, 1, 1, RT, 5, 6, 7, 1, 8'h40, 1, 5, 5, 0, 0, 0, 0, 0, 0);
      add(0, 1, 0, RT, 2, 3, 4, 0, 0, 0, 0, 0, 2'b10, 5, 0, 0, 0, 0);
      nop(8'hA0, 2, 3, 4, 0, 0, 2'b11, 5, 0, 0);
      nop(0, 0, 0, 0, 0, 4, 0, 0, 0, 0);
      nop(0, 0, 0, 0, 0, 0, 2'b01, 4, 0, 0);
      // flush alone
      add(0, 1, 1, AI, 1, 4, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      nop(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      // reset with three stages occupied
      add(0, 1, 0, AI, 1, 4, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      add(0, 1, 0, RT, 1, 2, 3, 0, 8'h70, 1, 4, 4, 0, 0, 0, 0, 0, 0);
      add(0, 1, 0, LW, 6, 5, 0, 0, 8'hA0, 1, 2, 3, 0, 4, 0, 0, 0, 0);
      add(1, 1, 0, AI, 5, 5, 5, 1, 8'h40, 6, 5, 5, 0, 3, 2'b01, 4, 0, 0);
      add(0, 1, 0, AI, 5, 5, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      foreach (vecs[i]) begin
         @(negedge clk);
         rst = vecs[i].rst; id_valid = vecs[i].valid; flush = vecs[i].flush;
         id_ctrl = vecs[i].ctrl; id_rs = vecs[i].rs; id_rt = vecs[i].rt; id_rd = vecs[i].rd;
         #1;
         if (vecs[i].chk) begin
            check(i, "stall",    32'(stall),    32'(vecs[i].e_stall));
            check(i, "ex_ctrl",  32'(ex_ctrl),  32'(vecs[i].e_exc));
            check(i, "ex_rs",    32'(ex_rs),    32'(vecs[i].e_exrs));
            check(i, "ex_rt",    32'(ex_rt),    32'(vecs[i].e_exrt));
            check(i, "ex_dst",   32'(ex_dst),   32'(vecs[i].e_exdst));
            check(i, "mem_ctrl", 32'(mem_ctrl), 32'(vecs[i].e_memc));
            check(i, "mem_dst",  32'(mem_dst),  32'(vecs[i].e_memdst));
            check(i, "wb_ctrl",  32'(wb_ctrl),  32'(vecs[i].e_wbc));
            check(i, "wb_dst",   32'(wb_dst),   32'(vecs[i].e_wbdst));
            check(i, "fwd_a",    32'(fwd_a),    32'(vecs[i].e_fa));
            check(i, "fwd_b",    32'(fwd_b),    32'(vecs[i].e_fb));
         end
      end

      // stall follows ID operands combinationally within one cycle
      @(negedge clk);
      rst = 0; flush = 0; id_valid = 1; id_ctrl = LW; id_rs = 1; id_rt = 5; id_rd = 0;
      @(negedge clk);
      id_ctrl = RT; id_rs = 5; id_rt = 6; id_rd = 7;
      #1 check(100, "stall_rs_match", 32'(stall), 32'd1);
      id_rs = 6;
      #1 check(101, "stall_no_match", 32'(stall), 32'd0);
      id_rt = 5;
      #1 check(102, "stall_rt_match", 32'(stall), 32'd1);
      id_valid = 0;
      #1 check(103, "stall_invalid",  32'(stall), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
